// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bridge and the control decoder.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Unsigned variants only exist for loads.
    function automatic logic lsu_legal(input logic store, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    return 1'b1;
            F3_H:    return !addr_lo[0];
            F3_W:    return addr_lo == 2'b00;
            F3_BU:   return !store;
            F3_HU:   return !store && !addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Data-memory bus between the load/store bridge (master) and memory (slave).
interface lsu_bus_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_be;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Shifts the returned bus word down to the accessed lane and extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = bus_rdata >> {addr_lo, 3'b000};

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata_ext = shifted;
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Runs one data-memory bus transaction per LOAD/STORE and stalls the core while it is in flight.
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              MemRW,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              mem_err,
    lsu_bus_bridge_if.master  bus
);

    lsu_state_t  state_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        legal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_word;

    assign legal = lsu_legal(MemRW, funct3, addr[1:0]);

    // Store lanes; loads reuse the same byte-enable pattern for the accessed bytes.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {addr[1], 1'b0};
                wdata_d = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_load_align (
        .bus_rdata (bus.bus_rdata),
        .addr_lo   (addr_lo_q),
        .funct3    (funct3_q),
        .rdata_ext (load_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_lo_q     <= '0;
            funct3_q      <= '0;
            rdata         <= '0;
            mem_err       <= 1'b0;
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
        end else begin
            mem_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_en) begin
                        if (legal) begin
                            bus.bus_valid <= 1'b1;
                            bus.bus_we    <= MemRW;
                            bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus.bus_wdata <= wdata_d;
                            bus.bus_be    <= be_d;
                            addr_lo_q     <= addr[1:0];
                            funct3_q      <= funct3;
                            state_q       <= REQ;
                        end else begin
                            mem_err <= 1'b1;
                            rdata   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ready) begin
                        bus.bus_valid <= 1'b0;
                        state_q       <= bus.bus_we ? DONE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (bus.bus_rvalid) begin
                        rdata   <= load_word;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Released in DONE so the core advances exactly once per access.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:        stall = mem_en & legal;
                REQ, WAIT_R: stall = 1'b1;
                default:     stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: directed table, random accesses, reset abort.
module tb_lsu_bus_bridge;
    import lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rw;
        int          rlat;
        int          rvd;
        logic        err;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] erd;
        int          st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en;
    logic        MemRW;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_err;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_bus_bridge_if #(.ADDR_W(32)) bus_if ();

    lsu_bus_bridge #(.ADDR_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_en  (mem_en),
        .MemRW   (MemRW),
        .funct3  (funct3),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .stall   (stall),
        .mem_err (mem_err),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rw, input int rlat,
                                input int rvd, input logic err, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] erd, input int st);
        vec_t v;
        v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.rw = rw; v.rlat = rlat; v.rvd = rvd;
        v.err = err; v.be = be; v.ewd = ewd; v.erd = erd; v.st = st;
        return v;
    endfunction

    // Reference: size in bytes, alignment by modulo, lanes by shift, extension by mask.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          size;
        int          off;
        logic [31:0] mask;
        logic [31:0] val;
        r = v;
        case (v.f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        off = int'(v.a[1:0]);
        if (size == 0) r.err = 1'b1;
        else r.err = ((off % size) != 0) || (v.we && v.f3[2]);
        if (size == 0) size = 4;
        r.be   = 4'(((1 << size) - 1) << off);
        mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        r.ewd  = (size == 1) ? v.wd[7:0] * 32'h0101_0101 :
                 (size == 2) ? v.wd[15:0] * 32'h0001_0001 : v.wd;
        val    = (v.rw >> (8 * off)) & mask;
        if (!v.f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        r.erd  = val;
        r.st   = v.we ? v.rlat + 2 : v.rlat + 2 + v.rvd;
        return r;
    endfunction

    // Acts as core and memory for one access; memory accepts after rlat wait cycles and
    // returns load data rvd cycles after the handshake.
    task automatic do_access(input vec_t v, input string tag);
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic [31:0] done_rdata;
        logic [3:0]  cap_be;
        logic        cap_we;
        logic        done_valid;
        bit          hs = 0;
        bit          done = 0;
        bit          err_seen = 0;
        int          nst = 0;
        int          waited = 0;
        int          after = 0;

        @(posedge clk);
        #1;
        mem_en = 1'b1; MemRW = v.we; funct3 = v.f3; addr = v.a; wdata = v.wd;
        bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0;

        if (v.err) begin
            @(negedge clk);
            chk({tag, " illegal stall"}, 32'(stall), 32'd0);
            @(posedge clk);
            #1 mem_en = 1'b0;
            @(negedge clk);
            chk({tag, " mem_err pulse"}, 32'(mem_err), 32'd1);
            chk({tag, " illegal rdata"}, rdata, 32'd0);
            chk({tag, " illegal bus_valid"}, 32'(bus_if.bus_valid), 32'd0);
            @(negedge clk);
            chk({tag, " mem_err width"}, 32'(mem_err), 32'd0);
            return;
        end

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (mem_err) err_seen = 1;
            if (!stall) begin
                done       = 1;
                done_rdata = rdata;
                done_valid = bus_if.bus_valid;
            end else begin
                nst++;
                bus_if.bus_ready  = 1'b0;
                bus_if.bus_rvalid = 1'b0;
                bus_if.bus_rdata  = $urandom;
                if (bus_if.bus_valid && !hs) begin
                    if (waited == v.rlat) begin
                        bus_if.bus_ready = 1'b1;
                        hs        = 1;
                        cap_addr  = bus_if.bus_addr;
                        cap_we    = bus_if.bus_we;
                        cap_be    = bus_if.bus_be;
                        cap_wdata = bus_if.bus_wdata;
                    end else begin
                        waited++;
                    end
                end else if (hs && !v.we) begin
                    after++;
                    if (after == v.rvd) begin
                        bus_if.bus_rvalid = 1'b1;
                        bus_if.bus_rdata  = v.rw;
                    end
                end
            end
        end

        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " stall cycles"}, 32'(nst), 32'(v.st));
        chk({tag, " bus_addr"}, cap_addr, v.a & 32'hFFFF_FFFC);
        chk({tag, " bus_we"}, 32'(cap_we), 32'(v.we));
        chk({tag, " no mem_err"}, 32'(err_seen), 32'd0);
        chk({tag, " done bus_valid"}, 32'(done_valid), 32'd0);
        if (v.we) begin
            chk({tag, " bus_be"}, 32'(cap_be), 32'(v.be));
            chk({tag, " bus_wdata"}, cap_wdata, v.ewd);
        end else begin
            chk({tag, " rdata"}, done_rdata, v.erd);
        end

        @(posedge clk);
        #1;
        mem_en = 1'b0; bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0;
    endtask

    vec_t vecs[13];
    vec_t rv;

    initial begin
        rst_n = 1'b0; mem_en = 1'b1; MemRW = 1'b0; funct3 = F3_W; addr = 32'h100; wdata = '0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset mem_err", 32'(mem_err), 32'd0);
        chk("reset bus_be", 32'(bus_if.bus_be), 32'd0);
        mem_en = 1'b0;
        rst_n  = 1'b1;

        vecs[0]  = mk(1, F3_W,  32'h100, 32'hDEADBEEF, 0, 0, 1, 0, 4'hF, 32'hDEADBEEF, 0, 2);
        vecs[1]  = mk(1, F3_B,  32'h103, 32'h000000A5, 0, 0, 1, 0, 4'h8, 32'hA5A5A5A5, 0, 2);
        vecs[2]  = mk(0, F3_B,  32'h102, 0, 32'h12F45678, 0, 3, 0, 0, 0, 32'hFFFFFFF4, 5);
        vecs[3]  = mk(0, F3_HU, 32'h102, 0, 32'h8001ABCD, 0, 1, 0, 0, 0, 32'h00008001, 3);
        vecs[4]  = mk(0, F3_W,  32'h101, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[5]  = mk(1, F3_H,  32'h102, 32'h1234BEEF, 0, 2, 1, 0, 4'hC, 32'hBEEFBEEF, 0, 4);
        vecs[6]  = mk(0, F3_H,  32'h100, 0, 32'h12348001, 1, 2, 0, 0, 0, 32'hFFFF8001, 5);
        vecs[7]  = mk(0, F3_BU, 32'h101, 0, 32'h1234F0AB, 0, 1, 0, 0, 0, 32'h000000F0, 3);
        vecs[8]  = mk(1, F3_H,  32'h101, 32'h1, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[9]  = mk(1, F3_BU, 32'h100, 32'h1, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[10] = mk(0, 3'b011, 32'h100, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, F3_W,  32'h104, 0, 32'hCAFEF00D, 0, 1, 0, 0, 0, 32'hCAFEF00D, 3);
        vecs[12] = mk(1, F3_B,  32'h100, 32'h1234567E, 0, 0, 1, 0, 4'h1, 32'h7E7E7E7E, 0, 2);

        for (int i = 0; i < 13; i++) do_access(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 200; i++) begin
            rv.we   = 1'($urandom_range(0, 1));
            rv.f3   = 3'($urandom_range(0, 7));
            rv.a    = $urandom;
            rv.wd   = $urandom;
            rv.rw   = $urandom;
            rv.rlat = $urandom_range(0, 3);
            rv.rvd  = $urandom_range(1, 3);
            do_access(model(rv), $sformatf("rnd%0d", i));
        end

        // Abort a load in WAIT_R with reset, then deliver a stale response.
        do_access(mk(0, F3_W, 32'h200, 0, 32'h5A5A1234, 0, 1, 0, 0, 0, 32'h5A5A1234, 3), "pre");
        @(posedge clk);
        #1;
        mem_en = 1'b1; MemRW = 1'b0; funct3 = F3_W; addr = 32'h300; bus_if.bus_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus_if.bus_ready = 1'b0;
        @(negedge clk);
        chk("abort in-flight stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort stall", 32'(stall), 32'd0);
        chk("abort bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("abort bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("abort bus_addr", bus_if.bus_addr, 32'd0);
        chk("abort bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("abort bus_be", 32'(bus_if.bus_be), 32'd0);
        chk("abort rdata", rdata, 32'd0);
        chk("abort mem_err", 32'(mem_err), 32'd0);
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 bus_if.bus_rvalid = 1'b0;
        @(negedge clk);
        chk("late rvalid rdata", rdata, 32'd0);
        chk("late rvalid stall", 32'(stall), 32'd0);
        chk("late rvalid bus_valid", 32'(bus_if.bus_valid), 32'd0);
        do_access(mk(1, F3_W, 32'h400, 32'h0BAD_F00D, 0, 1, 1, 0, 4'hF, 32'h0BADF00D, 0, 3),
                  "post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
